cl_axil_read_ctrl: RTL and testbench
====================================

// Module: cl_axil_read_ctrl
// PURPOSE
//  AXI4-Lite read-channel controller for the CL register space. Accepts one AR
//  beat at a time, range-checks it and issues a single-cycle request to the
//  internal register decode. It then returns the data on the R channel with
//  full VALID/READY compliance. Sits between the shell AXI-Lite slave port and
//  the register file. Exactly one read is outstanding at a time.
// PARAMETERS
//  ADDR_W       32            AXI address width
//  DATA_W       32            AXI/register data width
//  BASE_ADDR    32'h0000_0000 first valid byte address of the register window
//  WIN_BYTES    32'h0000_1000 window size in bytes; legal: BASE <= addr < BASE+WIN
//  TIMEOUT_CYC  256           WAIT cycles before abort (used only with timeout macro)
// PORTS
//  clk           in   1       clock
//  i_reset       in   1       asynchronous active-low reset
//  i_arvalid     in   1       AR valid from shell
//  o_arready     out  1       AR ready
//  i_araddr      in   ADDR_W  AR address
//  o_rvalid      out  1       R valid
//  i_rready      in   1       R ready from shell
//  o_rresp       out  2       R response: 00 OKAY, 10 SLVERR, 11 DECERR
//  o_rdata       out  DATA_W  R data
//  o_rd_req      out  1       one-cycle read strobe to register decode
//  o_rd_addr     out  ADDR_W  captured address, window-relative (addr-BASE)
//  i_rd_ack      in   1       register decode has data; qualifies i_rd_data/i_rd_err
//  i_rd_data     in   DATA_W  read data
//  i_rd_err      in   1       decode miss or slave error (valid with i_rd_ack)
// BEHAVIOUR
//  Reset (i_reset=0, async): state=IDLE.
//   - All outputs 0, including o_arready.
//   - o_arready rises on the first clk edge after reset release.
//  All outputs are registered. States:
//  IDLE: o_arready=1.
//   - On arvalid&arready: capture i_araddr and drop arready.
//   - In range and araddr[1:0]==0 -> REQ.
//   - Out of range -> RESP with rresp=11, rdata=0; no o_rd_req is issued.
//   - In range but misaligned -> RESP with rresp=10, rdata=0.
//  REQ: o_rd_req=1 for exactly one cycle, o_rd_addr=captured-BASE -> WAIT.
//  WAIT: on i_rd_ack, latch rdata=i_rd_data and rresp=i_rd_err?10:00 -> RESP.
//  RESP: o_rvalid=1; rdata and rresp stay stable until i_rready.
//   - On rvalid&rready: rvalid=0 -> IDLE; arready=1 on the following cycle.
//  Ack sampling: i_rd_ack is ignored in IDLE, REQ and RESP.
//   - A stray or late ack never produces a response.
//  Latency: AR handshake -> rvalid = 3 cycles when ack returns the cycle after
//   o_rd_req. Back-to-back reads: 1 idle cycle between R and the next AR.
//  i_rready held high before rvalid: the response completes in its first
//   RESP cycle.
//  i_arvalid during REQ/WAIT/RESP: not accepted (arready=0); shell holds it.
//  Reset mid-transaction: the transaction is dropped and not replayed.
// CONFIGURATION
//  CL_AXIL_RD_TIMEOUT_EN defined:
//   - A counter runs in WAIT, cleared on entry.
//   - After TIMEOUT_CYC cycles without ack -> RESP with rresp=10, rdata=0.
//   - Ack and timeout in the same cycle: ack wins.
//  Not defined: no counter; WAIT persists until ack.
// STRUCTURE
//  Package cl_axil_pkg:
//   - typedef enum logic[1:0] {IDLE,REQ,WAIT,RESP} rd_state_t
//   - constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
//  Single flat module; timeout counter inline, no sub-modules.
// TESTING
//  1 Read 0x10, ack next cycle with 0xCAFE_0001, rready=1
//    -> o_rd_addr=0x10, rvalid 3 cycles after AR, rdata=0xCAFE_0001, rresp=00.
//  2 Read 0x2000 (out of window)
//    -> no o_rd_req; rvalid with rresp=11, rdata=0.
//  3 Read 0x6 -> rresp=10, no o_rd_req.
//    i_rd_err=1 with ack -> rresp=10, rdata=i_rd_data.
//  4 rready low for 5 cycles, i_rd_data changes afterwards
//    -> rvalid, rdata and rresp stable throughout; arready stays 0 until 1 cycle
//    after the handshake.
//  5 Timeout macro on, TIMEOUT_CYC=8, no ack -> rresp=10 after 8 WAIT cycles.
//    Late ack in IDLE is ignored.
//    Ack and timeout in the same cycle -> rresp=00.
//  6 Assert i_reset in WAIT -> all outputs 0 immediately.
//    After release, a new read completes normally.

Source files
------------

// File: rtl/cl_axil_pkg.sv
// cl_axil_pkg: shared read-controller state encoding and AXI response codes
package cl_axil_pkg;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} rd_state_t;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
endpackage

// File: rtl/cl_axil_read_ctrl.sv
// cl_axil_read_ctrl: single-outstanding AXI4-Lite read controller for the CL register window
// Define CL_AXIL_RD_TIMEOUT_EN to abort WAIT with SLVERR after TIMEOUT_CYC cycles without ack.
module cl_axil_read_ctrl
  import cl_axil_pkg::*;
#(
  parameter int              ADDR_W      = 32,
  parameter int              DATA_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] WIN_BYTES = ADDR_W'(32'h0000_1000),
  parameter int              TIMEOUT_CYC = 256
) (
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_arvalid,
  output logic              o_arready,
  input  logic [ADDR_W-1:0] i_araddr,
  output logic              o_rvalid,
  input  logic              i_rready,
  output logic [1:0]        o_rresp,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_rd_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic              i_rd_ack,
  input  logic [DATA_W-1:0] i_rd_data,
  input  logic              i_rd_err
);
  rd_state_t         state_q, state_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d, rd_req_q, rd_req_d;
  logic [1:0]        rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, off;
  logic              in_range, tmo;

  assign off      = i_araddr - BASE_ADDR;
  assign in_range = (i_araddr >= BASE_ADDR) && (off < WIN_BYTES);

`ifdef CL_AXIL_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Counter sits at zero outside WAIT, so every WAIT entry starts a fresh count.
  assign cnt_d = (state_q == WAIT) ? cnt_q + 1'b1 : '0;
  assign tmo   = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
  always_ff @(posedge clk or negedge i_reset)
    if (!i_reset) cnt_q <= '0;
    else          cnt_q <= cnt_d;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    rd_req_d  = 1'b0;
    rd_addr_d = rd_addr_q;
    case (state_q)
      IDLE: begin
        arready_d = 1'b1;
        if (i_arvalid && arready_q) begin
          arready_d = 1'b0;
          rd_addr_d = off;
          rdata_d   = '0;
          if (!in_range) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_DECERR;
          end else if (|i_araddr[1:0]) begin
            state_d  = RESP;
            rvalid_d = 1'b1;
            rresp_d  = RESP_SLVERR;
          end else begin
            state_d  = REQ;
            rd_req_d = 1'b1;
          end
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (i_rd_ack) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = i_rd_data;
          rresp_d  = i_rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (tmo) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rdata_d  = '0;
          rresp_d  = RESP_SLVERR;
        end
      end
      RESP: begin
        if (i_rready) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      rd_req_q  <= rd_req_d;
      rd_addr_q <= rd_addr_d;
    end
  end

  assign o_arready = arready_q;
  assign o_rvalid  = rvalid_q;
  assign o_rresp   = rresp_q;
  assign o_rdata   = rdata_q;
  assign o_rd_req  = rd_req_q;
  assign o_rd_addr = rd_addr_q;
endmodule

// File: tb/tb_cl_axil_read_ctrl.sv
// tb_cl_axil_read_ctrl: directed vector bench for the AXI-Lite read controller
module tb_cl_axil_read_ctrl;
  logic        clk, i_reset, i_arvalid, o_arready, o_rvalid, i_rready;
  logic [31:0] i_araddr, o_rdata, o_rd_addr, i_rd_data;
  logic [1:0]  o_rresp;
  logic        o_rd_req, i_rd_ack, i_rd_err;
  int          n_chk = 0, n_fail = 0;

  cl_axil_read_ctrl #(.TIMEOUT_CYC(8)) dut (
    .clk(clk), .i_reset(i_reset), .i_arvalid(i_arvalid), .o_arready(o_arready),
    .i_araddr(i_araddr), .o_rvalid(o_rvalid), .i_rready(i_rready), .o_rresp(o_rresp),
    .o_rdata(o_rdata), .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_ack(i_rd_ack),
    .i_rd_data(i_rd_data), .i_rd_err(i_rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
    logic        req;
    int          lat;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic err, input int ack_at, input logic ereq, input int elat,
                         input logic [1:0] eresp, input logic [31:0] edata);
    int   lat, k;
    logic saw_req;
    logic [31:0] got_addr;
    k = 0;
    while (!o_arready && k < 10) begin step(); k++; end
    chk({tag, " arready_wait"}, 64'(o_arready), 64'd1);
    i_arvalid = 1'b1; i_araddr = addr; i_rd_data = data; i_rd_err = err;
    step();
    i_arvalid = 1'b0;
    lat = 1; saw_req = 1'b0; got_addr = '0;
    while (!o_rvalid && lat < 40) begin
      if (o_rd_req) begin saw_req = 1'b1; got_addr = o_rd_addr; end
      i_rd_ack = (lat == ack_at);
      step();
      lat++;
    end
    i_rd_ack = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " rd_req_seen"}, 64'(saw_req), 64'(ereq));
    if (ereq) chk({tag, " rd_addr"}, 64'(got_addr), 64'(addr));
    chk({tag, " rresp"}, 64'(o_rresp), 64'(eresp));
    chk({tag, " rdata"}, 64'(o_rdata), 64'(edata));
    chk({tag, " arready_in_resp"}, 64'(o_arready), 64'd0);
  endtask

  task automatic finish_r(input string tag);
    i_rready = 1'b1;
    step();
    chk({tag, " rvalid_drop"}, 64'(o_rvalid), 64'd0);
    chk({tag, " arready_gap"}, 64'(o_arready), 64'd0);
    step();
    chk({tag, " arready_back"}, 64'(o_arready), 64'd1);
  endtask

  initial begin
    vecs[0] = '{32'h0000_0010, 32'hCAFE_0001, 1'b0, 1'b1, 3, 2'b00, 32'hCAFE_0001};
    vecs[1] = '{32'h0000_2000, 32'h1111_1111, 1'b0, 1'b0, 1, 2'b11, 32'h0};
    vecs[2] = '{32'h0000_0006, 32'h2222_2222, 1'b0, 1'b0, 1, 2'b10, 32'h0};
    vecs[3] = '{32'h0000_0020, 32'h0000_1234, 1'b1, 1'b1, 3, 2'b10, 32'h0000_1234};
    vecs[4] = '{32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0, 1'b1, 3, 2'b00, 32'hDEAD_BEEF};
    vecs[5] = '{32'h0000_1000, 32'h3333_3333, 1'b0, 1'b0, 1, 2'b11, 32'h0};
    vecs[6] = '{32'h0000_0000, 32'h0BAD_F00D, 1'b0, 1'b1, 3, 2'b00, 32'h0BAD_F00D};

    i_reset = 1'b0; i_arvalid = 1'b0; i_araddr = '0; i_rready = 1'b1;
    i_rd_ack = 1'b0; i_rd_data = '0; i_rd_err = 1'b0;
    #12;
    chk("reset arready", 64'(o_arready), 64'd0);
    chk("reset rvalid", 64'(o_rvalid), 64'd0);
    chk("reset rd_req", 64'(o_rd_req), 64'd0);
    chk("reset rdata", 64'(o_rdata), 64'd0);
    chk("reset rresp", 64'(o_rresp), 64'd0);
    #5 i_reset = 1'b1;
    #1 chk("post-release arready", 64'(o_arready), 64'd0);
    step();
    chk("first-edge arready", 64'(o_arready), 64'd1);

    for (int i = 0; i < 7; i++) begin
      do_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].data, vecs[i].err, 2,
              vecs[i].req, vecs[i].lat, vecs[i].resp, vecs[i].rdata);
      finish_r($sformatf("vec%0d", i));
    end

    // stray ack while idle must not produce a response
    i_rd_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle stray ack rvalid", 64'(o_rvalid), 64'd0);
    end
    i_rd_ack = 1'b0;

    // R backpressure: response held stable while inputs wiggle
    i_rready = 1'b0;
    do_read("stall", 32'h30, 32'hAAAA_5555, 1'b0, 2, 1'b1, 3, 2'b00, 32'hAAAA_5555);
    for (int i = 0; i < 5; i++) begin
      i_rd_data = 32'h5000_0000 + 32'(i); i_rd_err = 1'b1; i_rd_ack = 1'b1;
      step();
      chk("stall rvalid", 64'(o_rvalid), 64'd1);
      chk("stall rdata", 64'(o_rdata), 64'hAAAA_5555);
      chk("stall rresp", 64'(o_rresp), 64'd0);
      chk("stall arready", 64'(o_arready), 64'd0);
    end
    i_rd_ack = 1'b0; i_rd_err = 1'b0;
    finish_r("stall");

    // async reset while in WAIT
    i_arvalid = 1'b1; i_araddr = 32'h40;
    step();
    i_arvalid = 1'b0;
    step();
    chk("pre-reset in wait rvalid", 64'(o_rvalid), 64'd0);
    i_reset = 1'b0;
    #1;
    chk("midreset arready", 64'(o_arready), 64'd0);
    chk("midreset rd_req", 64'(o_rd_req), 64'd0);
    chk("midreset rd_addr", 64'(o_rd_addr), 64'd0);
    chk("midreset rvalid", 64'(o_rvalid), 64'd0);
    #2 i_reset = 1'b1;
    do_read("post-reset", 32'h44, 32'h7777_0044, 1'b0, 2, 1'b1, 3, 2'b00, 32'h7777_0044);
    finish_r("post-reset");

`ifdef CL_AXIL_RD_TIMEOUT_EN
    do_read("timeout", 32'h48, 32'h9999_9999, 1'b0, -1, 1'b1, 10, 2'b10, 32'h0);
    finish_r("timeout");
    i_rd_ack = 1'b1;
    step();
    step();
    chk("late ack rvalid", 64'(o_rvalid), 64'd0);
    i_rd_ack = 1'b0;
    do_read("ack-at-timeout", 32'h4C, 32'h1357_9BDF, 1'b0, 9, 1'b1, 10, 2'b00, 32'h1357_9BDF);
    finish_r("ack-at-timeout");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
